// File: rtl/radix16_divider_gen.sv
// Radix-16 unsigned fixed-point divider: quotient = (dividend << FRAC_W) / divisor,
// producing one 4-bit quotient digit per ITER cycle from precomputed divisor multiples.
module radix16_divider_gen #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 24,
    parameter int QUOT_W     = 52
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  sticky,
    output logic                  div_by_zero,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int FRAC_W = QUOT_W - DIVIDEND_W;
    localparam int N      = QUOT_W / 4;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PR_W   = DIVISOR_W + 4;

    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

    state_t               state_q, state_d;
    logic [QUOT_W-1:0]    num_q, num_d;
    logic [DIVISOR_W-1:0] dsr_q, dsr_d;
    logic [PR_W-1:0]      mult_q [1:15];
    logic [PR_W-1:0]      mult_d [1:15];
    logic [DIVISOR_W-1:0] pr_q, pr_d;
    logic [QUOT_W-1:0]    qw_q, qw_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [QUOT_W-1:0]    quot_q, quot_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d;
    logic                 sticky_q, sticky_d;
    logic                 dbz_q, dbz_d;

    logic [PR_W-1:0]      shifted;
    logic [PR_W-1:0]      diff;
    logic [3:0]           digit;

    // Multiples are monotonic, so the last multiple not exceeding the shifted
    // remainder gives the largest legal digit; the difference is always < divisor.
    always_comb begin
        shifted = {pr_q, num_q[QUOT_W-1 -: 4]};
        digit   = 4'd0;
        diff    = shifted;
        for (int k = 1; k <= 15; k++) begin
            if (shifted >= mult_q[k]) begin
                digit = 4'(k);
                diff  = shifted - mult_q[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        dsr_d    = dsr_q;
        mult_d   = mult_q;
        pr_d     = pr_q;
        qw_d     = qw_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    num_d = QUOT_W'(dividend) << FRAC_W;
                    dsr_d = divisor;
                    if (divisor == '0) begin
                        quot_d   = '1;
                        rem_d    = '0;
                        sticky_d = 1'b0;
                        dbz_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    for (int k = 1; k <= 15; k++) begin
                        mult_d[k] = PR_W'(dsr_q) * PR_W'(k);
                    end
                    pr_d    = '0;
                    qw_d    = '0;
                    cnt_d   = CNT_W'(N);
                    state_d = ITER;
                end
            end
            ITER: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    pr_d  = diff[DIVISOR_W-1:0];
                    qw_d  = (qw_q << 4) | QUOT_W'(digit);
                    num_d = num_q << 4;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quot_d   = (qw_q << 4) | QUOT_W'(digit);
                        rem_d    = diff[DIVISOR_W-1:0];
                        sticky_d = |diff;
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            dsr_q    <= '0;
            for (int k = 1; k <= 15; k++) begin
                mult_q[k] <= '0;
            end
            pr_q     <= '0;
            qw_q     <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            dsr_q    <= dsr_d;
            mult_q   <= mult_d;
            pr_q     <= pr_d;
            qw_q     <= qw_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign sticky      = sticky_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_radix16_divider_gen.sv
// Directed-vector bench for radix16_divider_gen: a driver pushes expected results into a
// queue at each accept, and a monitor pops and compares whenever out_valid rises.
module tb_radix16_divider_gen;
  localparam int DW = 24;
  localparam int SW = 24;
  localparam int QW = 52;

  logic          clk;
  logic          nreset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          sticky;
  logic          div_by_zero;
  logic          busy;
  logic [1:0]    dbg_state;

  radix16_divider_gen #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .QUOT_W(QW)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .sticky(sticky),
    .div_by_zero(div_by_zero), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  typedef struct {
    logic [QW-1:0] q;
    logic [SW-1:0] r;
    logic          s;
    logic          z;
    int            lat;
    int            acc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  bit   seen   = 1'b0;
  bit   cur_ok = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!nreset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          cur_ok = 1'b0;
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no result pending");
        end else begin
          cur    = exp_q.pop_front();
          cur_ok = 1'b1;
          chk("quotient", 64'(quotient), 64'(cur.q));
          chk("remainder", 64'(remainder), 64'(cur.r));
          chk("sticky", 64'(sticky), 64'(cur.s));
          chk("div_by_zero", 64'(div_by_zero), 64'(cur.z));
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
        end
      end else if (cur_ok) begin
        chk("hold_quotient", 64'(quotient), 64'(cur.q));
        chk("hold_remainder", 64'(remainder), 64'(cur.r));
        chk("hold_sticky", 64'(sticky), 64'(cur.s));
        chk("hold_div_by_zero", 64'(div_by_zero), 64'(cur.z));
      end
    end else begin
      seen = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input logic [DW-1:0] dvd, input logic [SW-1:0] dsr, input bit push,
                       input logic [QW-1:0] eq, input logic [SW-1:0] er, input logic es,
                       input logic ez, input int elat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    @(posedge clk);
    #1;
    if (push) begin
      e.q = eq; e.r = er; e.s = es; e.z = ez; e.lat = elat; e.acc = cyc;
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = SW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", 64'(out_valid), 64'd1);
  endtask

  // directed vectors: dividend, divisor, quotient, remainder, sticky, div_by_zero, latency
  localparam int NV = 8;
  logic [DW-1:0] v_dvd [NV] = '{24'h800000, 24'h000001, 24'hFFFFFF, 24'h123456,
                                24'h000000, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};
  logic [SW-1:0] v_dsr [NV] = '{24'h800000, 24'h000003, 24'h000001, 24'h000000,
                                24'h000005, 24'hFFFFFF, 24'hFFFFFF, 24'h000003};
  logic [QW-1:0] v_q   [NV] = '{52'h0000010000000, 52'h0000005555555, 52'hFFFFFF0000000,
                                52'hFFFFFFFFFFFFF, 52'h0000000000000, 52'h0000010000000,
                                52'h0000000000010, 52'h5555550000000};
  logic [SW-1:0] v_r   [NV] = '{24'h0, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h10, 24'h0};
  logic          v_s   [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic          v_z   [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int            v_lat [NV] = '{15, 15, 15, 1, 15, 15, 15, 15};

  initial begin
    nreset    = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_sticky", 64'(sticky), 64'd0);
    chk("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      issue(v_dvd[i], v_dsr[i], 1'b1, v_q[i], v_r[i], v_s[i], v_z[i], v_lat[i]);
    end
    wait_idle();

    // consumer stall: results hold, no new accept until consumed
    out_ready = 1'b0;
    issue(24'h00000A, 24'h000003, 1'b1, 52'h0000035555555, 24'h1, 1'b1, 1'b0, 15);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_in_ready", 64'(in_ready), 64'd1);
    chk("consume_out_valid", 64'(out_valid), 64'd0);

    // abort in DONE acts as consumption
    out_ready = 1'b0;
    issue(24'h000002, 24'h000001, 1'b1, 52'h0000020000000, 24'h0, 1'b0, 1'b0, 15);
    wait_valid();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    out_ready = 1'b1;
    chk("abort_done_in_ready", 64'(in_ready), 64'd1);
    chk("abort_done_out_valid", 64'(out_valid), 64'd0);

    // abort in IDLE blocks acceptance
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    dividend = 24'h000005;
    divisor  = 24'h000001;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    abort    = 1'b0;

    // abort at the 4th ITER cycle
    issue(24'h123456, 24'h000789, 1'b0, '0, '0, 1'b0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_iter_state", 64'(dbg_state), 64'd2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_iter_in_ready", 64'(in_ready), 64'd1);
    chk("abort_iter_out_valid", 64'(out_valid), 64'd0);
    repeat (20) @(negedge clk);
    issue(24'h000007, 24'h000002, 1'b1, 52'h0000038000000, 24'h0, 1'b0, 1'b0, 15);
    wait_idle();

    // reset mid-operation
    issue(24'h123456, 24'h000789, 1'b0, '0, '0, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("midreset_quotient", 64'(quotient), 64'd0);
    chk("midreset_remainder", 64'(remainder), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_sticky", 64'(sticky), 64'd0);
    chk("midreset_div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    issue(24'd100, 24'd7, 1'b1, 52'h00000E4924924, 24'h4, 1'b1, 1'b0, 15);
    wait_idle();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/radix16_divider_gen.md
RADIX16_DIVIDER_GEN -- requirements
Module: radix16_divider_gen

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 24, dividend width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 24, divisor and remainder width in bits.
REQ-003 SHALL have parameter QUOT_W, default 52, quotient width; legal values are multiples of 4 with QUOT_W >= DIVIDEND_W; FRAC_W = QUOT_W - DIVIDEND_W; N = QUOT_W/4.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand offer.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port dividend  input  DIVIDEND_W  unsigned dividend.
REQ-009 SHALL have port divisor  input  DIVISOR_W  unsigned divisor.
REQ-010 SHALL have port abort  input  1  discard the operation in flight.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port quotient  output  QUOT_W  floor((dividend << FRAC_W) / divisor).
REQ-014 SHALL have port remainder  output  DIVISOR_W  (dividend << FRAC_W) mod divisor.
REQ-015 SHALL have port sticky  output  1  remainder != 0.
REQ-016 SHALL have port div_by_zero  output  1  divisor was 0.
REQ-017 SHALL have port busy  output  1  state != IDLE.

Function
REQ-018 SHALL implement the states IDLE, PREP, ITER and DONE; in_ready = (state == IDLE).
REQ-019 SHALL accept operands on a clock edge where in_valid && in_ready, register them, and move to PREP; if divisor == 0, it moves to DONE instead.
REQ-020 PREP (1 cycle) SHALL register multiples 1..15 of the divisor at DIVISOR_W+4 bits, then enter ITER with the digit counter = N.
REQ-021 Each ITER cycle SHALL shift 4 dividend bits into the partial remainder (DIVISOR_W+4 bits) and select the largest digit q in 0..15 for which the partial remainder minus q*divisor is non-negative.
REQ-022 Each ITER cycle SHALL store q as the next quotient digit, MSB digit first, write the difference back, and decrement the counter; when the counter is 1, the state goes to DONE.
REQ-023 The partial remainder SHALL always remain < divisor after each digit; there SHALL be no restoring step.
REQ-024 Latency SHALL be N+2 clocks from the accept edge to out_valid high; for divisor == 0 it SHALL be 1 clock.
REQ-025 In DONE, out_valid SHALL be 1, and quotient, remainder, sticky and div_by_zero SHALL hold stable until the edge where out_ready == 1; the state then goes to IDLE.
REQ-026 Divide by zero SHALL produce quotient = all ones, remainder = 0, sticky = 0 and div_by_zero = 1.
REQ-027 abort = 1 in PREP or ITER SHALL return the state to IDLE at the next edge with no out_valid; partial results SHALL be discarded.
REQ-028 abort = 1 in DONE SHALL be treated as consumption (state to IDLE); abort in IDLE SHALL have no effect and SHALL block acceptance that cycle.
REQ-029 New operands SHALL NOT be accepted in the DONE cycle in which out_ready = 1; in_ready rises in the following cycle.
REQ-030 dividend = 0 with a nonzero divisor SHALL run the full latency and return quotient = 0, remainder = 0.
REQ-031 Operand changes while busy SHALL have no effect.

Reset
REQ-032 nreset low SHALL asynchronously force state = IDLE, out_valid = 0, quotient = 0, remainder = 0, sticky = 0, div_by_zero = 0 and busy = 0; in_ready SHALL be 1 once nreset is high.
REQ-033 Reset asserted mid-operation SHALL discard the operation; the first accept after release SHALL produce a correct result.

Verification (defaults 24/24/52, FRAC_W = 28, N = 13)
REQ-034 dividend = 0x800000, divisor = 0x800000 -> quotient = 0x0000010000000, remainder = 0, sticky = 0, out_valid 15 clocks after accept.
REQ-035 dividend = 1, divisor = 3 -> quotient = 0x0000005555555, remainder = 1, sticky = 1; dividend = 0xFFFFFF, divisor = 1 -> quotient = 0xFFFFFF0000000, remainder = 0.
REQ-036 divisor = 0, dividend = 0x123456 -> 1 clock later out_valid = 1, div_by_zero = 1, quotient = 0xFFFFFFFFFFFFF, remainder = 0.
REQ-037 out_ready held low for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; out_ready = 1 -> next cycle in_ready = 1, out_valid = 0.
REQ-038 abort pulsed at the 4th ITER cycle -> out_valid never rises, in_ready = 1 next cycle; a following 7/2 division returns quotient = 0x0000038000000, remainder = 0.
REQ-039 nreset pulsed low during ITER -> all outputs 0 immediately; a following 100/7 division returns quotient = floor(100*2^28/7) = 0x00000E4924924, remainder = 4.
